// File: rtl/debug_pkg.sv
// Shared constants for the debug controller: UART command bytes and FSM state encoding.
// DEBUG_CTRL_CHECKSUM_EN adds the CSUM state used for the trailing checksum byte.
package debug_pkg;

  localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
  localparam logic [7:0] CMD_CONT  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_DUMP  = 8'h64;  // 'd'
  localparam logic [7:0] CMD_PAUSE = 8'h70;  // 'p'

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_STEP    = 3'd1;
  localparam logic [STATE_W-1:0] S_RUN     = 3'd2;
  localparam logic [STATE_W-1:0] S_LOAD    = 3'd3;
  localparam logic [STATE_W-1:0] S_SEND    = 3'd4;
  localparam logic [STATE_W-1:0] S_WAIT_TX = 3'd5;
`ifdef DEBUG_CTRL_CHECKSUM_EN
  localparam logic [STATE_W-1:0] S_CSUM    = 3'd6;
`endif

endpackage

// File: rtl/debug_ctrl_if.sv
// Host-side bus of the debug controller: UART byte stream, CPU run control and dump-word fetch.
// Signal names keep the controller's i_/o_ perspective; slave is the controller, master the host.
interface debug_ctrl_if #(
  parameter int unsigned NB        = 32,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned N_WORDS   = 33
);
  localparam int unsigned AW = $clog2(N_WORDS);

  logic                 i_uart_rx_ready;
  logic [DATA_BITS-1:0] i_uart_rx_data;
  logic                 i_uart_tx_done;
  logic                 i_mips_halt;
  logic [NB-1:0]        i_dump_word;
  logic [AW-1:0]        o_dump_addr;
  logic [DATA_BITS-1:0] o_uart_tx_data;
  logic                 o_uart_tx_start;
  logic                 o_step;
  logic                 o_run;

  modport master (
    output i_uart_rx_ready, i_uart_rx_data, i_uart_tx_done, i_mips_halt, i_dump_word,
    input  o_dump_addr, o_uart_tx_data, o_uart_tx_start, o_step, o_run
  );

  modport slave (
    input  i_uart_rx_ready, i_uart_rx_data, i_uart_tx_done, i_mips_halt, i_dump_word,
    output o_dump_addr, o_uart_tx_data, o_uart_tx_start, o_step, o_run
  );

endinterface

// File: rtl/debug_ctrl_word_serializer.sv
// Splits one NB-bit dump word into DATA_BITS-wide bytes, most significant byte first.
module word_serializer #(
  parameter int unsigned NB        = 32,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic                 i_shift,
  input  logic [NB-1:0]        i_word,
  output logic [DATA_BITS-1:0] o_byte_c,
  output logic                 o_last_c
);

  localparam int unsigned BYTES = NB / DATA_BITS;
  localparam int unsigned CW    = $clog2(BYTES) + 1;

  logic [NB-1:0] r_shift;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= r_shift << DATA_BITS;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign o_byte_c = r_shift[NB-1 -: DATA_BITS];
  assign o_last_c = (r_cnt == CW'(BYTES - 1));

endmodule

// File: rtl/debug_ctrl.sv
// UART debug controller: single-step / run / pause a CPU and stream PC + register file out byte-wise.
// Define DEBUG_CTRL_CHECKSUM_EN to append an XOR checksum byte after each dump.
module debug_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned NB        = 32,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned N_WORDS   = 33
) (
  input logic         i_clk,
  input logic         i_reset,
  debug_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(N_WORDS);

  logic [STATE_W-1:0]   r_state,   w_state_n;
  logic [DATA_BITS-1:0] r_tx_data, w_tx_data_n;
  logic                 r_tx_start, w_tx_start_n;
  logic                 r_step,    w_step_n;
  logic                 r_run,     w_run_n;
  logic [AW-1:0]        r_word_idx, w_word_idx_n;
`ifdef DEBUG_CTRL_CHECKSUM_EN
  logic [DATA_BITS-1:0] r_csum,      w_csum_n;
  logic                 r_csum_busy, w_csum_busy_n;
`endif

  logic                 w_load;
  logic                 w_shift;
  logic [DATA_BITS-1:0] w_byte;
  logic                 w_last;
  logic                 w_rx;

  word_serializer #(
    .NB        (NB),
    .DATA_BITS (DATA_BITS)
  ) u_ser (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_word   (bus.i_dump_word),
    .o_byte_c (w_byte),
    .o_last_c (w_last)
  );

  assign w_rx    = bus.i_uart_rx_ready;
  assign w_load  = (r_state == S_LOAD);
  assign w_shift = (r_state == S_WAIT_TX) && bus.i_uart_tx_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_step     <= 1'b0;
      r_run      <= 1'b0;
      r_word_idx <= '0;
`ifdef DEBUG_CTRL_CHECKSUM_EN
      r_csum      <= '0;
      r_csum_busy <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_tx_data  <= w_tx_data_n;
      r_tx_start <= w_tx_start_n;
      r_step     <= w_step_n;
      r_run      <= w_run_n;
      r_word_idx <= w_word_idx_n;
`ifdef DEBUG_CTRL_CHECKSUM_EN
      r_csum      <= w_csum_n;
      r_csum_busy <= w_csum_busy_n;
`endif
    end
  end

  // Next state plus next value of every registered output; step/run/start are high only while set here.
  always_comb begin
    w_state_n    = r_state;
    w_tx_data_n  = r_tx_data;
    w_tx_start_n = 1'b0;
    w_step_n     = 1'b0;
    w_run_n      = 1'b0;
    w_word_idx_n = r_word_idx;
`ifdef DEBUG_CTRL_CHECKSUM_EN
    w_csum_n      = r_csum;
    w_csum_busy_n = r_csum_busy;
`endif

    case (r_state)
      S_IDLE: begin
        w_word_idx_n = '0;
`ifdef DEBUG_CTRL_CHECKSUM_EN
        w_csum_n      = '0;
        w_csum_busy_n = 1'b0;
`endif
        if (w_rx && bus.i_uart_rx_data == DATA_BITS'(CMD_STEP)) begin
          w_state_n = S_STEP;
          w_step_n  = 1'b1;
        end else if (w_rx && bus.i_uart_rx_data == DATA_BITS'(CMD_CONT)) begin
          w_state_n = S_RUN;
          w_run_n   = 1'b1;
        end else if (w_rx && bus.i_uart_rx_data == DATA_BITS'(CMD_DUMP)) begin
          w_state_n = S_LOAD;
        end
      end

      S_STEP: w_state_n = S_LOAD;

      S_RUN: begin
        if (bus.i_mips_halt || (w_rx && bus.i_uart_rx_data == DATA_BITS'(CMD_PAUSE))) begin
          w_state_n = S_LOAD;
        end else begin
          w_run_n = 1'b1;
        end
      end

      S_LOAD: w_state_n = S_SEND;

      S_SEND: begin
        w_tx_data_n  = w_byte;
        w_tx_start_n = 1'b1;
        w_state_n    = S_WAIT_TX;
`ifdef DEBUG_CTRL_CHECKSUM_EN
        w_csum_n     = r_csum ^ w_byte;
`endif
      end

      S_WAIT_TX: begin
        if (bus.i_uart_tx_done) begin
          if (!w_last) begin
            w_state_n = S_SEND;
          end else if (r_word_idx != AW'(N_WORDS - 1)) begin
            w_word_idx_n = r_word_idx + AW'(1);
            w_state_n    = S_LOAD;
          end else begin
`ifdef DEBUG_CTRL_CHECKSUM_EN
            w_state_n = S_CSUM;
`else
            w_state_n = S_IDLE;
`endif
          end
        end
      end

`ifdef DEBUG_CTRL_CHECKSUM_EN
      // First cycle issues the checksum byte, then wait for its done strobe.
      S_CSUM: begin
        if (!r_csum_busy) begin
          w_tx_data_n   = r_csum;
          w_tx_start_n  = 1'b1;
          w_csum_busy_n = 1'b1;
        end else if (bus.i_uart_tx_done) begin
          w_csum_busy_n = 1'b0;
          w_state_n     = S_IDLE;
        end
      end
`endif

      default: w_state_n = S_IDLE;
    endcase
  end

  assign bus.o_dump_addr     = r_word_idx;
  assign bus.o_uart_tx_data  = r_tx_data;
  assign bus.o_uart_tx_start = r_tx_start;
  assign bus.o_step          = r_step;
  assign bus.o_run           = r_run;

endmodule
